// File: rtl/trigger_hls_deadlock_watchdog_pkg.sv
// Shared types and report-word layout for the AXIS deadlock watchdog.
package trigger_wd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    REPORT = 2'd2,
    HOLD   = 2'd3
  } wd_state_e;

  localparam int RPT_W     = 32;
  localparam int FIRST_LSB = 24;
  localparam int FIRST_W   = 8;
  localparam int MASK_LSB  = 16;
  localparam int MASK_W    = 8;
  localparam int CNT_LSB   = 0;
  localparam int CNT_FW    = 16;

endpackage

// File: rtl/trigger_hls_deadlock_watchdog_if.sv
// Report channel: one valid/ready word per trip.
interface trigger_hls_deadlock_watchdog_if;
  import trigger_wd_pkg::*;

  logic             rpt_valid;
  logic             rpt_ready;
  logic [RPT_W-1:0] rpt_data;

  modport master (output rpt_valid, output rpt_data, input rpt_ready);
  modport slave  (input rpt_valid, input rpt_data, output rpt_ready);
endinterface

// File: rtl/trigger_hls_deadlock_watchdog_prienc.sv
// Lowest-index priority encoder; returns 0 when nothing is set.
module trigger_wd_prienc #(
  parameter int N_CH = 8
) (
  input  logic [N_CH-1:0] vec_i,
  output logic [2:0]      idx_o
);
  always_comb begin
    idx_o = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = 3'(i);
    end
  end
endmodule

// File: rtl/trigger_hls_deadlock_watchdog.sv
// Stall timer over the AXIS block flags; latches the stuck channels on
// threshold and hands one report word to the control/status block.
module trigger_hls_deadlock_watchdog
  import trigger_wd_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [CNT_W-1:0] cfg_thresh,
  input  logic [N_CH-1:0]  axis_block_sigs,
  input  logic             inst_idle,
  input  logic             clear,
  output logic             block,
  output logic             tripped,
  output logic [N_CH-1:0]  trip_mask,
  output logic [2:0]       trip_first,
  output logic [CNT_W-1:0] stall_cycles,
  trigger_hls_deadlock_watchdog_if.master rpt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  wd_state_e        state_q, state_d;
  logic [N_CH-1:0]  blk_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             trip_q, trip_d;
  logic [N_CH-1:0]  mask_q, mask_d;
  logic [2:0]       first_q, first_d, first_enc;
  logic             stalled;

  trigger_wd_prienc #(.N_CH(N_CH)) u_prienc (
    .vec_i (blk_q),
    .idx_o (first_enc)
  );

  assign block   = |blk_q;
  assign stalled = block && !inst_idle;
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      blk_q   <= '0;
      cnt_q   <= '0;
      trip_q  <= 1'b0;
      mask_q  <= '0;
      first_q <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= axis_block_sigs;
      cnt_q   <= cnt_d;
      trip_q  <= trip_d;
      mask_q  <= mask_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    trip_d  = trip_q;
    mask_d  = mask_q;
    first_d = first_q;
    // clear outranks both a same-cycle trip and a same-cycle handshake
    if (clear) begin
      cnt_d   = '0;
      trip_d  = 1'b0;
      mask_d  = '0;
      first_d = '0;
      state_d = enable ? ARMED : IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (enable) state_d = ARMED;
        end
        ARMED: begin
          if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (stalled) begin
            cnt_d = cnt_inc;
            if (cfg_thresh != '0 && cnt_inc == cfg_thresh) begin
              state_d = REPORT;
              trip_d  = 1'b1;
              mask_d  = blk_q;
              first_d = first_enc;
            end
          end else begin
            cnt_d = '0;
          end
        end
        REPORT: if (rpt.rpt_ready) state_d = HOLD;
        HOLD:   ;
        default: state_d = IDLE;
      endcase
    end
  end

  assign tripped      = trip_q;
  assign trip_mask    = mask_q;
  assign trip_first   = first_q;
  assign stall_cycles = cnt_q;
  assign rpt.rpt_valid = (state_q == REPORT);

  always_comb begin
    rpt.rpt_data = '0;
    rpt.rpt_data[FIRST_LSB +: FIRST_W] = FIRST_W'(first_q);
    rpt.rpt_data[MASK_LSB  +: MASK_W]  = MASK_W'(mask_q);
    rpt.rpt_data[CNT_LSB   +: CNT_FW]  = CNT_FW'(cnt_q);
  end

endmodule
